alu_sequencer: RTL

- Command-side driver for the 32-bit combinational ALU.
- Accepts operation requests over a valid/ready command channel and drives the ALU's A/B/Ctl inputs from registers.
- Captures the ALU result and flags, then returns them over a valid/ready response channel.
- Fills the ALU's unimplemented MUL slot with an iterative shift-add multiply that reuses the ALU's ADD path; the ALU itself is instantiated beside this block, not inside it.

---
 rtl/alu_pkg.sv | 36 +++
 rtl/alu_seq_mul_ctrl.sv | 56 +++++
 rtl/alu_sequencer.sv | 119 +++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU command sequencer: op codes, FSM states, bus types.
// No logic here; imported by every sequencer file.
package alu_pkg;

  localparam int DATA_W = 32;

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_SUB  = 3'd1;
  localparam logic [2:0] OP_XOR  = 3'd2;
  localparam logic [2:0] OP_SLT  = 3'd3;
  localparam logic [2:0] OP_MUL  = 3'd4;
  localparam logic [2:0] OP_SLLV = 3'd5;
  localparam logic [2:0] OP_SRAV = 3'd6;
  localparam logic [2:0] OP_SRLV = 3'd7;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    EXEC     = 2'd1,
    MUL_STEP = 2'd2,
    RESP     = 2'd3
  } seq_state_t;

  typedef struct packed {
    logic [2:0]        op;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
  } cmd_t;

  typedef struct packed {
    logic [DATA_W-1:0] result;
    logic              zero;
    logic              overflow;
    logic              cout;
  } rsp_t;

endpackage

// File: rtl/alu_seq_mul_ctrl.sv
// Shift-add multiply state (acc/mcand/mplier/count); the add itself is done by the external ALU.
// Latency: one step per enabled cycle, done flags the final step; no backpressure, stepping is owner-paced.
// Backpressure: none internally; the owning FSM holds step low to stall.
module alu_seq_mul_ctrl
  import alu_pkg::*;
#(
  parameter int MUL_CYCLES     = 32,
  parameter int MUL_EARLY_EXIT = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              step,
  input  logic [DATA_W-1:0] start_mcand,
  input  logic [DATA_W-1:0] start_mplier,
  input  logic [DATA_W-1:0] sum,
  output logic              done,
  output logic [DATA_W-1:0] acc,
  output logic [DATA_W-1:0] acc_nxt,
  output logic [DATA_W-1:0] mcand
);

  localparam int CNT_W = $clog2(MUL_CYCLES + 1);

  logic [DATA_W-1:0] mplier;
  logic [DATA_W-1:0] mplier_shift;
  logic [CNT_W-1:0]  count;
  logic [CNT_W-1:0]  count_inc;

  assign mplier_shift = mplier >> 1;
  assign count_inc    = count + 1'b1;
  // sum is acc + mcand from the ALU; only taken when this multiplier bit is set
  assign acc_nxt      = mplier[0] ? sum : acc;
  assign done         = step && ((count_inc == CNT_W'(MUL_CYCLES)) ||
                                 ((MUL_EARLY_EXIT != 0) && (mplier_shift == '0)));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      count  <= '0;
    end else if (start) begin
      acc    <= '0;
      mcand  <= start_mcand;
      mplier <= start_mplier;
      count  <= '0;
    end else if (step) begin
      acc    <= acc_nxt;
      mcand  <= mcand << 1;
      mplier <= mplier_shift;
      count  <= count_inc;
    end
  end

endmodule

// File: rtl/alu_sequencer.sv
// Drives an external 32-bit ALU from registered operands and returns result/flags; MUL done by shift-add.
// Latency: response 1 edge after accept for non-MUL, N edges after accept for an N-step MUL.
// Backpressure: one op in flight; cmd_ready low until the response is taken via rsp_ready.
module alu_sequencer
  import alu_pkg::*;
#(
  parameter int MUL_CYCLES     = 32,
  parameter int MUL_EARLY_EXIT = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [2:0]        cmd_op,
  input  logic [DATA_W-1:0] cmd_a,
  input  logic [DATA_W-1:0] cmd_b,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_result,
  output logic              rsp_zero,
  output logic              rsp_overflow,
  output logic              rsp_cout,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [2:0]        alu_ctl,
  input  logic [DATA_W-1:0] alu_out,
  input  logic              alu_zero,
  input  logic              alu_overflow,
  input  logic              alu_cout
);

  seq_state_t        state;
  seq_state_t        state_nxt;
  cmd_t              cmd_q;
  rsp_t              rsp_q;
  logic              live;
  logic              accept;
  logic              mul_start;
  logic              mul_step;
  logic              mul_done;
  logic [DATA_W-1:0] mul_acc;
  logic [DATA_W-1:0] mul_acc_nxt;
  logic [DATA_W-1:0] mul_mcand;

  // live holds cmd_ready off until the first edge after reset release
  assign cmd_ready = live && (state == IDLE);
  assign accept    = cmd_valid && cmd_ready;
  assign rsp_valid = (state == RESP);
  assign mul_start = accept && (cmd_op == OP_MUL);
  assign mul_step  = (state == MUL_STEP);

  assign rsp_result   = rsp_q.result;
  assign rsp_zero     = rsp_q.zero;
  assign rsp_overflow = rsp_q.overflow;
  assign rsp_cout     = rsp_q.cout;

  always_comb begin
    state_nxt = state;
    alu_a     = cmd_q.a;
    alu_b     = cmd_q.b;
    alu_ctl   = cmd_q.op;
    case (state)
      IDLE: begin
        if (accept) state_nxt = (cmd_op == OP_MUL) ? MUL_STEP : EXEC;
      end
      EXEC: state_nxt = RESP;
      MUL_STEP: begin
        alu_a   = mul_acc;
        alu_b   = mul_mcand;
        alu_ctl = OP_ADD;
        if (mul_done) state_nxt = RESP;
      end
      RESP: begin
        if (rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      live  <= 1'b0;
      cmd_q <= '0;
      rsp_q <= '0;
    end else begin
      live <= 1'b1;
      if (accept) cmd_q <= '{op: cmd_op, a: cmd_a, b: cmd_b};
      if (state == EXEC) begin
        rsp_q <= '{result: alu_out, zero: alu_zero, overflow: alu_overflow, cout: alu_cout};
      end else if (mul_done) begin
        // low word of the product is sign-agnostic; overflow/carry are not meaningful here
        rsp_q <= '{result: mul_acc_nxt, zero: (mul_acc_nxt == '0), overflow: 1'b0, cout: 1'b0};
      end
    end
  end

  alu_seq_mul_ctrl #(
    .MUL_CYCLES     (MUL_CYCLES),
    .MUL_EARLY_EXIT (MUL_EARLY_EXIT)
  ) u_mul_ctrl (
    .clk          (clk),
    .reset_n      (reset_n),
    .start        (mul_start),
    .step         (mul_step),
    .start_mcand  (cmd_a),
    .start_mplier (cmd_b),
    .sum          (alu_out),
    .done         (mul_done),
    .acc          (mul_acc),
    .acc_nxt      (mul_acc_nxt),
    .mcand        (mul_mcand)
  );

endmodule
